// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encodings, opcodes, ALU op codes and control-word type for multicycle_ctrl
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC     = 4'd6,
      R_WB     = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      ADDI_EX  = 4'd10,
      ADDI_WB  = 4'd11
   } state_e;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory wait cycles and flags a timeout
// Ports: clk, rst_n (async active-low); cnt_en_i = in a memory state with mem_ready low;
//        timeout_o = count has reached MEM_TIMEOUT while still waiting.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cnt_en_i,
   output logic timeout_o
);

   logic [7:0] cnt_q, cnt_d;

   assign timeout_o = cnt_en_i && (cnt_q == 8'(MEM_TIMEOUT));
   // Any cycle that is not a continuing wait either leaves the state or aborts, so the count restarts.
   assign cnt_d = (cnt_en_i && !timeout_o) ? cnt_q + 8'd1 : 8'd0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= 8'd0;
      else cnt_q <= cnt_d;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control FSM with memory-wait timeout
// Ports: clk, rst_n (async active-low); opcode, zero, mem_ready in;
//        datapath strobes/mux selects, state (debug) and mem_err (timeout pulse) out.
// Macro MULTICYCLE_ADDI_EN adds the ADDI_EX/ADDI_WB path; without it addi is unsupported.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic [3:0] state,
   output logic       mem_err
);

   state_e state_q, state_d;
   ctrl_t  ctrl;
   logic   mem_wait, timeout, unused_zero;

   // Branch condition is applied in the datapath (pc_write_cond & zero).
   assign unused_zero = zero;

   assign mem_wait = (state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR) && !mem_ready;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt_en_i  (mem_wait),
      .timeout_o (timeout)
   );

   always_comb begin
      state_d = state_q;
      ctrl = '0;
      case (state_q)
         FETCH: begin
            ctrl.mem_read = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.alu_op = ALU_ADD;
            ctrl.pc_write = mem_ready;
            ctrl.ir_write = mem_ready;
            state_d = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            ctrl.alu_src_b = 2'b11;
            ctrl.alu_op = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_RTYPE: state_d = EXEC;
               OP_BEQ: state_d = BRANCH;
               OP_J: state_d = JUMP;
`ifdef MULTICYCLE_ADDI_EN
               OP_ADDI: state_d = ADDI_EX;
`endif
               default: state_d = FETCH;
            endcase
         end
         MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.alu_op = ALU_ADD;
            state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d = 1'b1;
            state_d = mem_ready ? MEM_WB : MEM_RD;
         end
         MEM_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            state_d = FETCH;
         end
         MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d = 1'b1;
            state_d = mem_ready ? FETCH : MEM_WR;
         end
         EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op = ALU_FUNCT;
            state_d = R_WB;
         end
         R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst = 1'b1;
            state_d = FETCH;
         end
         BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source = 2'b01;
            state_d = FETCH;
         end
         JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_source = 2'b10;
            state_d = FETCH;
         end
`ifdef MULTICYCLE_ADDI_EN
         ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.alu_op = ALU_ADD;
            state_d = ADDI_WB;
         end
         ADDI_WB: begin
            ctrl.reg_write = 1'b1;
            state_d = FETCH;
         end
`endif
         default: state_d = FETCH;
      endcase
      // A timed-out access is abandoned: suppress its strobes and restart at FETCH.
      if (timeout) begin
         ctrl = '0;
         state_d = FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= FETCH;
      else state_q <= state_d;

   assign {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source} = ctrl;
   assign state = state_q;
   assign mem_err = timeout;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized self-checking bench for multicycle_ctrl against an instruction-level trace model
module tb_multicycle_ctrl;

   localparam int T = 4;

   logic       clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, mem_err;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;
   logic [16:0] dut_vec;

   int errors = 0, checks = 0;
   int q_st[$];
   bit q_rdy[$], q_err[$];
   logic [5:0] q_op[$];
   logic [5:0] bop;

   multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state(state), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   assign dut_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, mem_err};

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Required outputs for a named step of an instruction, taken from the control table.
   function automatic logic [16:0] exp_vec(int st, bit rdy, bit err);
      logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0;
      logic [1:0] asb = 0, aop = 0, ps = 0;
      if (err) return 17'd1;
      case (st)
         0: begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
         1: asb = 2'b11;
         2: begin asa = 1; asb = 2'b10; end
         3: begin mr = 1; iod = 1; end
         4: begin rw = 1; m2r = 1; end
         5: begin mw = 1; iod = 1; end
         6: begin asa = 1; aop = 2'b10; end
         7: begin rw = 1; rd = 1; end
         8: begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
         9: begin pw = 1; ps = 2'b10; end
         10: begin asa = 1; asb = 2'b10; end
         11: rw = 1;
         default: ;
      endcase
      return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, 1'b0};
   endfunction

   function automatic bit rb(bit rnd);
      return rnd ? 1'($urandom) : 1'b1;
   endfunction

   task automatic push(int st, bit rdy, bit err);
      q_st.push_back(st);
      q_rdy.push_back(rdy);
      q_err.push_back(err);
      q_op.push_back(bop);
   endtask

   // A memory step: some wait cycles, then completion or (randomly) a timeout abort.
   task automatic mem_stage(int st, bit rnd, output bit aborted);
      int w = 0;
      aborted = 0;
      if (rnd && $urandom_range(0, 4) == 0) begin
         for (int i = 0; i < T; i++) push(st, 0, 0);
         push(st, 0, 1);
         aborted = 1;
         return;
      end
      if (rnd) w = $urandom_range(0, T);
      for (int i = 0; i < w; i++) push(st, 0, 0);
      push(st, 1, 0);
   endtask

   // Expected step sequence of one instruction from fetch to its last step.
   task automatic build(logic [5:0] op, bit rnd);
      bit ab;
      bop = op;
      mem_stage(0, rnd, ab);
      if (ab) return;
      push(1, rb(rnd), 0);
      case (op)
         6'b100011: begin push(2, rb(rnd), 0); mem_stage(3, rnd, ab); if (!ab) push(4, rb(rnd), 0); end
         6'b101011: begin push(2, rb(rnd), 0); mem_stage(5, rnd, ab); end
         6'b000000: begin push(6, rb(rnd), 0); push(7, rb(rnd), 0); end
         6'b000100: push(8, rb(rnd), 0);
         6'b000010: push(9, rb(rnd), 0);
`ifdef MULTICYCLE_ADDI_EN
         6'b001000: begin push(10, rb(rnd), 0); push(11, rb(rnd), 0); end
`endif
         default: ;
      endcase
   endtask

   task automatic hold_reset();
      @(negedge clk);
      rst_n = 0;
      mem_ready = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      mem_ready = 1;
      #1;
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++;
      if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
      checks++;
      if (dut_vec !== exp_vec(0, 1, 0)) begin errors++; $display("FAIL reset_outs_rdy1: got %h want %h", dut_vec, exp_vec(0, 1, 0)); end
      mem_ready = 0;
      #1;
      checks++;
      if (dut_vec !== exp_vec(0, 0, 0)) begin errors++; $display("FAIL reset_outs_rdy0: got %h want %h", dut_vec, exp_vec(0, 0, 0)); end
   endtask

   task automatic test_directed();
      logic [5:0] ops[7] = '{6'b100011, 6'b000100, 6'b111111, 6'b001000, 6'b000000, 6'b101011, 6'b000010};
      hold_reset();
      foreach (ops[k]) build(ops[k], 0);
      while (q_st.size() > 0) begin
         @(negedge clk);
         rst_n = 1;
         mem_ready = q_rdy[0];
         opcode = q_op[0];
         #1;
         checks++;
         if (state !== 4'(q_st[0])) begin errors++; $display("FAIL directed_state op=%b: got %0d want %0d", q_op[0], state, q_st[0]); end
         checks++;
         if (dut_vec !== exp_vec(q_st[0], q_rdy[0], q_err[0])) begin errors++; $display("FAIL directed_outs op=%b st=%0d: got %h want %h", q_op[0], q_st[0], dut_vec, exp_vec(q_st[0], q_rdy[0], q_err[0])); end
         void'(q_st.pop_front()); void'(q_rdy.pop_front()); void'(q_err.pop_front()); void'(q_op.pop_front());
      end
   endtask

   task automatic test_timeout();
      hold_reset();
      bop = 6'b101011;
      push(0, 1, 0); push(1, 1, 0); push(2, 1, 0);
      for (int i = 0; i < T; i++) push(5, 0, 0);
      push(5, 0, 1);
      for (int i = 0; i < T; i++) push(0, 0, 0);
      push(0, 0, 1);
      for (int i = 0; i < T; i++) push(0, 0, 0);
      push(0, 1, 0); push(1, 1, 0); push(2, 1, 0);
      for (int i = 0; i < T; i++) push(5, 0, 0);
      push(5, 1, 0);
      bop = 6'b100011;
      push(0, 1, 0); push(1, 1, 0); push(2, 1, 0);
      for (int i = 0; i < T; i++) push(3, 0, 0);
      push(3, 0, 1);
      push(0, 1, 0);
      while (q_st.size() > 0) begin
         @(negedge clk);
         rst_n = 1;
         mem_ready = q_rdy[0];
         opcode = q_op[0];
         #1;
         checks++;
         if (state !== 4'(q_st[0])) begin errors++; $display("FAIL timeout_state: got %0d want %0d", state, q_st[0]); end
         checks++;
         if (dut_vec !== exp_vec(q_st[0], q_rdy[0], q_err[0])) begin errors++; $display("FAIL timeout_outs st=%0d err=%0d: got %h want %h", q_st[0], q_err[0], dut_vec, exp_vec(q_st[0], q_rdy[0], q_err[0])); end
         void'(q_st.pop_front()); void'(q_rdy.pop_front()); void'(q_err.pop_front()); void'(q_op.pop_front());
      end
   endtask

   task automatic test_reset_mid();
      hold_reset();
      opcode = 6'b100011;
      @(negedge clk); rst_n = 1; mem_ready = 1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); mem_ready = 0;
      #1;
      checks++;
      if (state !== 4'd3) begin errors++; $display("FAIL midreset_pre_state: got %0d want 3", state); end
      #2 rst_n = 0;
      #1;
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL midreset_state: got %0d want 0", state); end
      checks++;
      if (dut_vec !== exp_vec(0, 0, 0)) begin errors++; $display("FAIL midreset_outs: got %h want %h", dut_vec, exp_vec(0, 0, 0)); end
      @(negedge clk); rst_n = 1; mem_ready = 1;
      #1;
      checks++;
      if (dut_vec !== exp_vec(0, 1, 0)) begin errors++; $display("FAIL midreset_first_fetch: got %h want %h", dut_vec, exp_vec(0, 1, 0)); end
      @(negedge clk);
      #1;
      checks++;
      if (state !== 4'd1) begin errors++; $display("FAIL midreset_decode: got %0d want 1", state); end
   endtask

   task automatic test_random();
      logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
      logic [5:0] op;
      hold_reset();
      for (int n = 0; n < 60; n++) begin
         int k = $urandom_range(0, 6);
         if (k < 6) op = ops[k];
         else begin
            op = 6'($urandom);
            while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000}) op = 6'($urandom);
         end
         build(op, 1);
      end
      while (q_st.size() > 0) begin
         @(negedge clk);
         rst_n = 1;
         mem_ready = q_rdy[0];
         opcode = q_op[0];
         #1;
         checks++;
         if (state !== 4'(q_st[0])) begin errors++; $display("FAIL random_state op=%b: got %0d want %0d", q_op[0], state, q_st[0]); end
         checks++;
         if (dut_vec !== exp_vec(q_st[0], q_rdy[0], q_err[0])) begin errors++; $display("FAIL random_outs op=%b st=%0d: got %h want %h", q_op[0], q_st[0], dut_vec, exp_vec(q_st[0], q_rdy[0], q_err[0])); end
         void'(q_st.pop_front()); void'(q_rdy.pop_front()); void'(q_err.pop_front()); void'(q_op.pop_front());
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the number of consecutive wait cycles with mem_ready low before abort (range 1..255).
REQ-002 SHALL have ports: clk input 1, rising-edge clock.
REQ-003 rst_n input 1, asynchronous active-low reset.
REQ-004 opcode input 6, instruction opcode field from the instruction register.
REQ-005 zero input 1, ALU zero flag.
REQ-006 mem_ready input 1, memory access completes this cycle.
REQ-007 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a output 1 each, datapath strobes and mux selects.
REQ-008 alu_src_b, alu_op, pc_source output 2 each; alu_op feeds the ALU control decoder (00 add, 01 sub, 10 funct-decoded).
REQ-009 state output 4, current state for debug; mem_err output 1, one-cycle timeout pulse.

Function
REQ-010 SHALL be a single FSM with states and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11.
REQ-011 Outputs SHALL be combinational from state only, except that pc_write and ir_write in FETCH are qualified by mem_ready; all unlisted outputs are 0.
REQ-012 FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00, i_or_d=0; on mem_ready go to DECODE, else stay.
REQ-013 DECODE: alu_src_b=11, alu_op=00; next state by opcode: 100011/101011 to MEM_ADDR, 000000 to EXEC, 000100 to BRANCH, 000010 to JUMP, 001000 to ADDI_EX; any other opcode goes to FETCH with no register or memory write.
REQ-014 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEM_RD if opcode is 100011, else MEM_WR.
REQ-015 MEM_RD: mem_read=1, i_or_d=1; on mem_ready go to MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-016 MEM_WR: mem_write=1, i_or_d=1; on mem_ready go to FETCH.
REQ-017 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-018 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then FETCH. The zero flag is gated by the datapath, not the FSM.
REQ-019 JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-020 Instruction latency in cycles, excluding extra memory waits: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-021 An 8-bit wait counter SHALL increment each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0, and clear on every state change.
REQ-022 When the wait counter equals MEM_TIMEOUT with mem_ready=0, the FSM SHALL pulse mem_err for one cycle, deassert that cycle's strobes, and go to FETCH.
REQ-023 If mem_ready is 1 in the same cycle the timeout is reached, the completion SHALL win and no mem_err is raised.
REQ-024 Unused encodings 12..15 SHALL go to FETCH on the next clock.

Reset
REQ-025 rst_n low SHALL force state=FETCH, wait counter=0 and mem_err=0 immediately, regardless of clk.
REQ-026 Reset asserted mid-instruction SHALL abandon the instruction; after release, FETCH outputs apply from the first cycle.

Configuration
REQ-027 With macro MULTICYCLE_ADDI_EN defined, ADDI_EX (alu_src_a=1, alu_src_b=10, alu_op=00, then ADDI_WB) and ADDI_WB (reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH) SHALL exist.
REQ-028 Without MULTICYCLE_ADDI_EN, opcode 001000 SHALL be treated as unsupported and encodings 10 and 11 as unused.

Structure
REQ-029 State encodings, opcode constants and alu_op codes SHALL live in the shared package mips_ctrl_pkg.
REQ-030 The wait counter and timeout compare SHALL be the sub-module mem_wait_timer; next-state and output decode stay in multicycle_ctrl.

Verification
REQ-031 lw (100011), mem_ready tied 1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-032 beq (000100) -> states 0,1,8,0; pc_write_cond=1, pc_source=01, alu_op=01 in state 8.
REQ-033 MEM_TIMEOUT=4, sw with mem_ready held 0 in MEM_WR -> mem_err pulses once after 4 wait cycles, mem_write=0 that cycle, next state 0.
REQ-034 Opcode 111111 in DECODE -> next state 0; no reg_write, mem_write or pc_write asserted.
REQ-035 rst_n dropped between clock edges while in MEM_RD -> state=0 immediately and mem_read follows FETCH values.
REQ-036 addi (001000) with and without MULTICYCLE_ADDI_EN -> states 0,1,10,11,0 versus 0,1,0.
